// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop synchronized A/B, one-cycle Up/Down pulses, sticky Err, saturating 0..31 Position.
// Define QDEC_GLITCH_FILTER_EN to require 3 identical synchronized samples before a pair is accepted.
module quad_decoder (
   input  logic       CLK,
   input  logic       RST,
   input  logic       A,
   input  logic       B,
   input  logic       Clr,
   output logic       Up,
   output logic       Down,
   output logic       Err,
   output logic [4:0] Position,
   output logic       High,
   output logic       Low
);

`ifdef QDEC_GLITCH_FILTER_EN
   localparam logic [2:0] ARM_CYC = 3'd4;
`else
   localparam logic [2:0] ARM_CYC = 3'd2;
`endif
   localparam logic [4:0] POS_MAX = 5'd31;

   logic [1:0] ab_p0;
   logic [1:0] ab_p1;
   logic [1:0] acc_pair;
   logic [1:0] cand;
   logic [2:0] arm_cnt;
   logic       armed;
   logic       fwd;
   logic       rev;
   logic       ill;

   function automatic logic [4:0] sat_inc(input logic [4:0] v);
      return (v == POS_MAX) ? v : v + 5'd1;
   endfunction

   function automatic logic [4:0] sat_dec(input logic [4:0] v);
      return (v == 5'd0) ? v : v - 5'd1;
   endfunction

   // Stage p0/p1: two-flop synchronizer on the raw encoder pair
   always_ff @(posedge CLK) begin
      if (RST) begin
         ab_p0 <= 2'b00;
         ab_p1 <= 2'b00;
      end else begin
         ab_p0 <= {A, B};
         ab_p1 <= ab_p0;
      end
   end

`ifdef QDEC_GLITCH_FILTER_EN
   logic [1:0] ab_p2;
   logic [1:0] ab_p3;

   // Stage p2/p3: sample history; a pair counts only once three samples agree
   always_ff @(posedge CLK) begin
      if (RST) begin
         ab_p2 <= 2'b00;
         ab_p3 <= 2'b00;
      end else begin
         ab_p2 <= ab_p1;
         ab_p3 <= ab_p2;
      end
   end

   assign cand = ((ab_p1 == ab_p2) && (ab_p2 == ab_p3)) ? ab_p1 : acc_pair;
`else
   assign cand = ab_p1;
`endif

   assign armed = (arm_cnt == ARM_CYC);

   always_comb begin
      fwd = 1'b0;
      rev = 1'b0;
      ill = 1'b0;
      case ({acc_pair, cand})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
         4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: rev = 1'b1;
         4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: ill = 1'b1;
         default: ;
      endcase
   end

   // Decode stage: pulses, accepted pair and position all register on the same edge.
   // While arming, the accepted pair follows the value entering the last synchronizer
   // stage so the first armed comparison sees no spurious step.
   always_ff @(posedge CLK) begin
      if (RST) begin
         arm_cnt  <= 3'd0;
         acc_pair <= 2'b00;
         Up       <= 1'b0;
         Down     <= 1'b0;
         Err      <= 1'b0;
         Position <= 5'd0;
      end else if (!armed) begin
         arm_cnt  <= arm_cnt + 3'd1;
         acc_pair <= ab_p0;
         Up       <= 1'b0;
         Down     <= 1'b0;
         if (Clr) begin
            Position <= 5'd0;
            Err      <= 1'b0;
         end
      end else begin
         acc_pair <= cand;
         Up       <= fwd;
         Down     <= rev;
         if (Clr) begin
            Position <= 5'd0;
            Err      <= 1'b0;
         end else begin
            if (fwd)
               Position <= sat_inc(Position);
            else if (rev)
               Position <= sat_dec(Position);
            if (ill)
               Err <= 1'b1;
         end
      end
   end

   assign High = (Position == POS_MAX);
   assign Low  = (Position == 5'd0);

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: a Gray-code step model predicts every output each cycle,
// plus hand-computed checks of counts, positions, flags and latency.
module tb_quad_decoder;

`ifdef QDEC_GLITCH_FILTER_EN
   localparam int LAT  = 4;
   localparam int ARM  = 4;
   localparam bit FILT = 1'b1;
`else
   localparam int LAT  = 2;
   localparam int ARM  = 2;
   localparam bit FILT = 1'b0;
`endif
   localparam int H = LAT + 2;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       A   = 1'b0;
   logic       B   = 1'b0;
   logic       Clr = 1'b0;
   logic       Up;
   logic       Down;
   logic       Err;
   logic [4:0] Position;
   logic       High;
   logic       Low;

   quad_decoder dut (
      .CLK(CLK), .RST(RST), .A(A), .B(B), .Clr(Clr),
      .Up(Up), .Down(Down), .Err(Err), .Position(Position), .High(High), .Low(Low)
   );

   always #5 CLK = ~CLK;

   int n_chk   = 0;
   int n_pass  = 0;
   int cyc_n   = 0;
   int ups     = 0;
   int dns     = 0;
   int up_mark = -1;
   int start;

   // model state: m_hist[0] is the sample taken at the previous edge, m_hist[1] the one before, ...
   logic [1:0] m_hist [4];
   logic [1:0] m_acc;
   int         m_pos;
   bit         m_up;
   bit         m_dn;
   bit         m_err;
   int         m_arm;
   logic [1:0] seqv [4];

   function automatic int gidx(input logic [1:0] p);
      case (p)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp)
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_n);
      else
         n_pass++;
   endtask

   task automatic model_edge(input logic [1:0] x, input bit rst, input bit clr);
      logic [1:0] c;
      int d;
      if (rst) begin
         for (int i = 0; i < 4; i++) m_hist[i] = 2'b00;
         m_acc = 2'b00; m_pos = 0; m_up = 0; m_dn = 0; m_err = 0; m_arm = 0;
      end else begin
         if (m_arm < ARM) begin
            m_acc = m_hist[0];
            m_up  = 0;
            m_dn  = 0;
            m_arm++;
            if (clr) begin m_pos = 0; m_err = 0; end
         end else begin
            if (FILT)
               c = (m_hist[1] == m_hist[2] && m_hist[2] == m_hist[3]) ? m_hist[1] : m_acc;
            else
               c = m_hist[1];
            d = (gidx(c) - gidx(m_acc)) & 3;
            m_up = (d == 1);
            m_dn = (d == 3);
            if (clr) begin
               m_pos = 0;
               m_err = 0;
            end else begin
               if (d == 1 && m_pos < 31) m_pos++;
               if (d == 3 && m_pos > 0) m_pos--;
               if (d == 2) m_err = 1;
            end
            m_acc = c;
         end
         for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = x;
      end
   endtask

   task automatic cyc(input logic [1:0] ab, input bit clr, input bit rst);
      logic [9:0] act;
      logic [9:0] exp;
      {A, B} = ab;
      Clr    = clr;
      RST    = rst;
      @(posedge CLK);
      model_edge(ab, rst, clr);
      #1;
      cyc_n++;
      act = {Up, Down, Err, Position, High, Low};
      exp = {m_up, m_dn, m_err, 5'(m_pos), (m_pos == 31), (m_pos == 0)};
      chk("cycle", int'(act), int'(exp));
      if (Up) begin
         ups++;
         if (up_mark < 0) up_mark = cyc_n;
      end
      if (Down) dns++;
   endtask

   task automatic drive(input logic [1:0] ab, input int n);
      repeat (n) cyc(ab, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      seqv[0] = 2'b00; seqv[1] = 2'b01; seqv[2] = 2'b11; seqv[3] = 2'b10;

      // reset held with A=B=1, then release and hold
      repeat (3) cyc(2'b11, 1'b0, 1'b1);
      chk("rst_pos", int'(Position), 0);
      chk("rst_low", int'(Low), 1);
      chk("rst_high", int'(High), 0);
      ups = 0; dns = 0;
      repeat (10) cyc(2'b11, 1'b0, 1'b0);
      chk("arm_ups", ups, 0);
      chk("arm_dns", dns, 0);
      chk("arm_err", int'(Err), 0);
      chk("arm_low", int'(Low), 1);

      // four forward steps from 00
      repeat (2) cyc(2'b00, 1'b0, 1'b1);
      drive(2'b00, ARM + 2);
      ups = 0; up_mark = -1; start = cyc_n;
      drive(2'b01, H); drive(2'b11, H); drive(2'b10, H); drive(2'b00, H);
      chk("fwd4_ups", ups, 4);
      chk("fwd4_pos", int'(Position), 4);
      chk("fwd4_latency", up_mark - (start + 1), LAT);

      // saturation at 31, then one reverse step
      cyc(2'b00, 1'b1, 1'b0);
      chk("clr_pos", int'(Position), 0);
      ups = 0;
      for (int i = 1; i <= 33; i++) begin
         drive(seqv[i % 4], H);
         if (i == 31) begin
            chk("sat31_pos", int'(Position), 31);
            chk("sat31_high", int'(High), 1);
         end
      end
      chk("sat_ups", ups, 33);
      chk("sat_pos", int'(Position), 31);
      drive(2'b00, H);
      chk("rev_pos", int'(Position), 30);
      chk("rev_high", int'(High), 0);

      // illegal 00->11, forward 11->10 keeps Err, Clr clears
      ups = 0; dns = 0;
      drive(2'b11, H);
      chk("ill_err", int'(Err), 1);
      chk("ill_pulses", ups + dns, 0);
      chk("ill_pos", int'(Position), 30);
      drive(2'b10, H);
      chk("ill_fwd_ups", ups, 1);
      chk("ill_fwd_err", int'(Err), 1);
      chk("ill_fwd_pos", int'(Position), 31);
      cyc(2'b10, 1'b1, 1'b0);
      chk("clr_err", int'(Err), 0);
      chk("clr_pos2", int'(Position), 0);

      // Clr coincident with a Down pulse at Position 5
      drive(2'b00, H); drive(2'b01, H); drive(2'b11, H); drive(2'b10, H); drive(2'b00, H);
      chk("pos5", int'(Position), 5);
      for (int k = 0; k <= LAT + 1; k++) begin
         cyc(2'b10, (k == LAT), 1'b0);
         if (k == LAT) begin
            chk("clrdn_down", int'(Down), 1);
            chk("clrdn_pos", int'(Position), 0);
         end
      end

      // Clr coincident with an illegal transition
      for (int k = 0; k <= LAT + 1; k++) begin
         cyc(2'b01, (k == LAT), 1'b0);
         if (k == LAT) chk("clrill_err", int'(Err), 0);
      end
      chk("clrill_err_after", int'(Err), 0);

      // reset mid-step drops the pulse in flight
      ups = 0;
      cyc(2'b11, 1'b0, 1'b0);
      cyc(2'b11, 1'b0, 1'b1);
      cyc(2'b11, 1'b0, 1'b1);
      drive(2'b11, ARM + H);
      chk("rstmid_ups", ups, 0);
      chk("rstmid_pos", int'(Position), 0);
      chk("rstmid_low", int'(Low), 1);

`ifdef QDEC_GLITCH_FILTER_EN
      // 2-cycle glitch on A is ignored; a 3-cycle level change is accepted
      ups = 0; dns = 0;
      drive(2'b01, 2);
      drive(2'b11, H + 2);
      chk("glitch_pulses", ups + dns, 0);
      chk("glitch_err", int'(Err), 0);
      up_mark = -1; start = cyc_n;
      drive(2'b10, 3);
      drive(2'b10, H);
      chk("filt_ups", ups, 1);
      chk("filt_latency", up_mark - (start + 1), 4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of the clock.
REQ-002 The port `CLK` SHALL be an input, 1 bit wide, and is the system clock.
REQ-003 The port `RST` SHALL be an input, 1 bit wide, and is the synchronous, active-high reset.
REQ-004 The port `A` SHALL be an input, 1 bit wide, carrying the asynchronous quadrature channel A from the encoder.
REQ-005 The port `B` SHALL be an input, 1 bit wide, carrying the asynchronous quadrature channel B from the encoder.
REQ-006 The port `Clr` SHALL be an input, 1 bit wide, that synchronously clears `Position` and `Err`.
REQ-007 The port `Up` SHALL be an output, 1 bit wide, giving a one-cycle pulse per forward step, directly drivable into an up/down counter Up input.
REQ-008 The port `Down` SHALL be an output, 1 bit wide, giving a one-cycle pulse per reverse step.
REQ-009 The port `Err` SHALL be an output, 1 bit wide, as a sticky illegal-transition flag.
REQ-010 The port `Position` SHALL be an output, 5 bits wide, giving the saturating step count 0..31.
REQ-011 The port `High` SHALL be an output, 1 bit wide, and SHALL equal (`Position` == 31).
REQ-012 The port `Low` SHALL be an output, 1 bit wide, and SHALL equal (`Position` == 0).

Function
REQ-013 `A` and `B` SHALL each pass through a 2-flop synchronizer before use.
REQ-014 The decoder SHALL compare the current synchronized pair {A,B} to the previously accepted pair every cycle.
REQ-015 A forward step SHALL be 00->01, 01->11, 11->10 or 10->00; it SHALL pulse `Up` for exactly one cycle.
REQ-016 A reverse step SHALL be the inverse of the forward sequence; it SHALL pulse `Down` for exactly one cycle.
REQ-017 An unchanged pair SHALL produce no pulse.
REQ-018 A change of both bits (00<->11, 01<->10) SHALL set `Err`, SHALL produce no `Up` or `Down`, and SHALL update the accepted pair to the new value.
REQ-019 `Up` and `Down` SHALL never be high in the same cycle.
REQ-020 Latency: a new pair value that is stable from sample edge n SHALL assert the pulse after edge n+2 and deassert it after edge n+3.
REQ-021 On a forward step, `Position` SHALL increment by 1 and saturate at 31; `Up` SHALL still pulse when saturated.
REQ-022 On a reverse step, `Position` SHALL decrement by 1 and saturate at 0; `Down` SHALL still pulse when saturated.
REQ-023 `Position` SHALL update in the same cycle that the `Up` or `Down` pulse is asserted.
REQ-024 When `Clr` is high, `Position` SHALL become 0 and `Err` SHALL become 0 on the next edge, overriding any step in that cycle; the `Up`/`Down` pulse SHALL still be emitted.
REQ-025 When `Clr` and an illegal transition occur in the same cycle, `Clr` SHALL win and `Err` SHALL become 0.
REQ-026 `Err` SHALL remain high until `Clr` or `RST` is asserted.

Reset
REQ-027 While `RST` is high, the synchronizers SHALL be 00, the accepted pair SHALL be 00, `Up`=0, `Down`=0, `Err`=0, `Position`=0, `High`=0 and `Low`=1.
REQ-028 For the first 2 cycles after `RST` deasserts (arm window), decoding SHALL be disabled: the accepted pair SHALL track the synchronized pair, and no `Up`, `Down` or `Err` SHALL be generated.
REQ-029 `RST` asserted mid-operation SHALL take effect on the next edge, overriding `Clr` and any pending step; any pulse in flight SHALL be dropped.

Configuration
REQ-030 The macro `QDEC_GLITCH_FILTER_EN` SHALL control an optional glitch filter.
REQ-031 When `QDEC_GLITCH_FILTER_EN` is defined, a synchronized pair SHALL be accepted only after it is identical for 3 consecutive samples; latency SHALL become n+4/n+5, and the arm window SHALL become 4 cycles.
REQ-032 When `QDEC_GLITCH_FILTER_EN` is defined, a 1- or 2-cycle pulse on `A` or `B` SHALL be ignored.
REQ-033 When `QDEC_GLITCH_FILTER_EN` is not defined, there SHALL be no filter logic, and REQ-020 latency and the REQ-028 arm window SHALL apply.

Verification
REQ-034 Scenario: reset release with A=1, B=1, then hold for 10 cycles -> no `Up`/`Down`/`Err`; `Position`=0, `Low`=1.
REQ-035 Scenario: 4 forward steps (00,01,11,10,00), each held 4 cycles -> 4 single-cycle `Up` pulses; `Position`=4; each pulse appears 2 edges after its sample edge.
REQ-036 Scenario: 33 forward steps from 0 -> `Position` stops at 31 and `High`=1 after step 31; `Up` pulses 33 times; then 1 reverse step -> `Position`=30, `High`=0.
REQ-037 Scenario: from accepted 00, drive A=1, B=1 simultaneously -> `Err`=1, no pulse, `Position` unchanged; then forward 11->10 -> `Up` pulse and `Err` stays 1; then `Clr`=1 for 1 cycle -> `Err`=0, `Position`=0.
REQ-038 Scenario: `Clr` asserted in the same cycle a `Down` pulse is emitted at `Position`=5 -> `Down` pulse seen; `Position`=0 on the next cycle.
REQ-039 Scenario: with `QDEC_GLITCH_FILTER_EN` defined, a 2-cycle glitch on A -> no pulse; a 3-cycle level change -> one `Up` pulse at the n+4 edge.
